// File: rtl/eaf_pkg.sv
// rtl/eaf_pkg.sv - shared types and default hash constants for the evicted-address filter
package eaf_pkg;

  localparam logic [31:0] EAF_HASH_C1 = 32'h5555_5555;
  localparam logic [31:0] EAF_HASH_C2 = 32'h9e37_79b9;

  typedef enum logic {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } eaf_state_e;

  typedef struct packed {
    logic        valid;
    logic        insert;
    logic [31:0] h2;
  } eaf_s1_t;

endpackage

// File: rtl/eaf_hash.sv
// rtl/eaf_hash.sv - combinational two-round multiplicative hash of a line address
module eaf_hash
  import eaf_pkg::*;
#(
  parameter int          ADDR_W = 32,
  parameter logic [31:0] C1     = EAF_HASH_C1,
  parameter logic [31:0] C2     = EAF_HASH_C2
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic [31:0]       h2_o
);

  logic [31:0] a;
  logic [31:0] h1;

  generate
    if (ADDR_W >= 32) begin : g_trunc
      assign a = addr_i[31:0];
    end else begin : g_zext
      assign a = {{(32-ADDR_W){1'b0}}, addr_i};
    end
  endgenerate

  assign h1   = (a ^ (a >> 16)) * C1;
  assign h2_o = (h1 ^ (h1 >> 16)) * C2;

endmodule

// File: rtl/eaf_bloom_filter.sv
// rtl/eaf_bloom_filter.sv - pipelined multi-hash Bloom filter of recently evicted cache lines
module eaf_bloom_filter
  import eaf_pkg::*;
#(
  parameter int          ADDR_W      = 32,
  parameter int          NUM_HASH    = 4,
  parameter int          IDX_W       = 8,
  parameter int          MAX_INSERTS = 16,
  parameter int          CNT_W       = $clog2(MAX_INSERTS + 1),
  parameter logic [31:0] HASH_C1     = EAF_HASH_C1,
  parameter logic [31:0] HASH_C2     = EAF_HASH_C2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_insert,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              clear_i,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic              resp_insert,
  output logic [CNT_W-1:0]  insert_count,
  output logic              clear_event
);

  localparam int DEPTH = 1 << IDX_W;

  eaf_state_e                         state_q, state_d;
  eaf_s1_t                            s1_q, s1_d;
  logic [NUM_HASH-1:0][DEPTH-1:0]     bits_q, bits_d;
  logic [CNT_W-1:0]                   cnt_q, cnt_d;
  logic                               resp_valid_q, resp_valid_d;
  logic                               resp_hit_q, resp_hit_d;
  logic                               resp_insert_q, resp_insert_d;
  logic                               clear_event_q, clear_event_d;

  logic [31:0]      h2;
  logic             accept;
  logic             s2_fire;
  logic             all_set;
  logic             auto_clear;
  logic             do_clear;
  logic [CNT_W-1:0] cnt_inc;

  eaf_hash #(
    .ADDR_W (ADDR_W),
    .C1     (HASH_C1),
    .C2     (HASH_C2)
  ) u_hash (
    .addr_i (req_addr),
    .h2_o   (h2)
  );

  assign req_ready = (state_q == RUN);
  assign accept    = req_valid && req_ready;
  assign s2_fire   = (state_q == RUN) && s1_q.valid;
  assign cnt_inc   = cnt_q + CNT_W'(1);

  // Hit is evaluated on the pre-write array contents, so an insert reports prior membership.
  always_comb begin
    all_set = 1'b1;
    for (int i = 0; i < NUM_HASH; i++) begin
      if (!bits_q[i][s1_q.h2[i*IDX_W +: IDX_W]]) all_set = 1'b0;
    end
  end

  assign auto_clear = s2_fire && s1_q.insert && (cnt_inc == CNT_W'(MAX_INSERTS));
  assign do_clear   = clear_i || auto_clear;

  always_comb begin
    state_d       = RUN;
    s1_d          = s1_q;
    bits_d        = bits_q;
    cnt_d         = cnt_q;
    resp_valid_d  = s2_fire;
    resp_hit_d    = resp_hit_q;
    resp_insert_d = resp_insert_q;
    clear_event_d = do_clear;

    if (do_clear) state_d = CLEAR;

    if (state_q == RUN) begin
      s1_d.valid  = accept;
      s1_d.insert = req_insert;
      s1_d.h2     = h2;
    end

    if (s2_fire) begin
      resp_hit_d    = all_set;
      resp_insert_d = s1_q.insert;
    end

    if (do_clear) begin
      bits_d = '0;
      cnt_d  = '0;
    end else if (s2_fire && s1_q.insert) begin
      cnt_d = cnt_inc;
      for (int i = 0; i < NUM_HASH; i++) begin
        bits_d[i][s1_q.h2[i*IDX_W +: IDX_W]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= CLEAR;
      s1_q          <= '0;
      bits_q        <= '0;
      cnt_q         <= '0;
      resp_valid_q  <= 1'b0;
      resp_hit_q    <= 1'b0;
      resp_insert_q <= 1'b0;
      clear_event_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      s1_q          <= s1_d;
      bits_q        <= bits_d;
      cnt_q         <= cnt_d;
      resp_valid_q  <= resp_valid_d;
      resp_hit_q    <= resp_hit_d;
      resp_insert_q <= resp_insert_d;
      clear_event_q <= clear_event_d;
    end
  end

  assign resp_valid   = resp_valid_q;
  assign resp_hit     = resp_hit_q;
  assign resp_insert  = resp_insert_q;
  assign insert_count = cnt_q;
  assign clear_event  = clear_event_q;

endmodule

// File: tb/tb_eaf_bloom_filter.sv
// tb/tb_eaf_bloom_filter.sv - directed self-checking bench for eaf_bloom_filter
module tb_eaf_bloom_filter;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_insert;
  logic [31:0] req_addr;
  logic        clear_i;
  logic        resp_valid;
  logic        resp_hit;
  logic        resp_insert;
  logic [4:0]  insert_count;
  logic        clear_event;

  int n_vec;
  int n_err;

  logic [1:0] rq[$];
  bit         mdl[4][256];

  eaf_bloom_filter dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_insert   (req_insert),
    .req_addr     (req_addr),
    .clear_i      (clear_i),
    .resp_valid   (resp_valid),
    .resp_hit     (resp_hit),
    .resp_insert  (resp_insert),
    .insert_count (insert_count),
    .clear_event  (clear_event)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (resp_valid) rq.push_back({resp_insert, resp_hit});

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mhash(input logic [31:0] a);
    logic [31:0] x;
    logic [31:0] h1;
    x  = a ^ (a >> 16);
    h1 = x * 32'h5555_5555;
    x  = h1 ^ (h1 >> 16);
    return x * 32'h9e37_79b9;
  endfunction

  function automatic logic mdl_hit(input logic [31:0] a);
    logic [31:0] h;
    logic        r;
    h = mhash(a);
    r = 1'b1;
    for (int i = 0; i < 4; i++) if (!mdl[i][h[i*8 +: 8]]) r = 1'b0;
    return r;
  endfunction

  task automatic mdl_ins(input logic [31:0] a);
    logic [31:0] h;
    h = mhash(a);
    for (int i = 0; i < 4; i++) mdl[i][h[i*8 +: 8]] = 1'b1;
  endtask

  task automatic mdl_clr();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 256; j++) mdl[i][j] = 1'b0;
  endtask

  task automatic send(input logic ins, input logic [31:0] a);
    int w;
    w          = 0;
    req_valid  = 1'b1;
    req_insert = ins;
    req_addr   = a;
    while (!req_ready && w < 20) begin
      tick();
      w++;
    end
    if (!req_ready) chk("ready_timeout", 32'd0, 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic expect_resp(input string tag, input logic ins, input logic hit);
    logic [1:0] r;
    int         w;
    w = 0;
    while (rq.size() == 0 && w < 10) begin
      tick();
      w++;
    end
    if (rq.size() == 0) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      r = rq.pop_front();
      chk({tag, "_op"},  {31'd0, r[1]}, {31'd0, ins});
      chk({tag, "_hit"}, {31'd0, r[0]}, {31'd0, hit});
    end
  endtask

  initial begin
    logic [31:0] adr[16];
    int          n_ce;
    int          n_nr;

    n_vec      = 0;
    n_err      = 0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_insert = 1'b0;
    req_addr   = '0;
    clear_i    = 1'b0;
    mdl_clr();

    repeat (3) tick();
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rvalid", {31'd0, resp_valid}, 32'd0);
    chk("rst_rhit", {31'd0, resp_hit}, 32'd0);
    chk("rst_rins", {31'd0, resp_insert}, 32'd0);
    chk("rst_count", {27'd0, insert_count}, 32'd0);
    chk("rst_cevent", {31'd0, clear_event}, 32'd0);
    rst = 1'b0;
    chk("post_rst_ready0", {31'd0, req_ready}, 32'd0);
    tick();
    chk("post_rst_ready1", {31'd0, req_ready}, 32'd1);

    // latency: nothing visible after the accept edge, response after the following one
    send(1'b0, 32'h0000_0000);
    chk("lat_s1_rvalid", {31'd0, resp_valid}, 32'd0);
    tick();
    chk("lat_s2_rvalid", {31'd0, resp_valid}, 32'd1);
    chk("lat_s2_hit", {31'd0, resp_hit}, 32'd0);
    chk("lat_s2_ins", {31'd0, resp_insert}, 32'd0);
    tick();
    chk("pulse_rvalid", {31'd0, resp_valid}, 32'd0);
    rq.delete();

    send(1'b1, 32'h1234_5680);
    send(1'b0, 32'h1234_5680);
    expect_resp("ins_x", 1'b1, 1'b0);
    expect_resp("test_x", 1'b0, 1'b1);
    mdl_ins(32'h1234_5680);
    repeat (2) tick();
    chk("count_1", {27'd0, insert_count}, 32'd1);

    // address 0 hashes to index 0 in every slice
    send(1'b1, 32'h0000_0000);
    send(1'b0, 32'h0000_0000);
    send(1'b0, 32'h0000_0001);
    expect_resp("ins_0", 1'b1, mdl_hit(32'h0));
    mdl_ins(32'h0);
    expect_resp("test_0", 1'b0, 1'b1);
    expect_resp("test_1", 1'b0, mdl_hit(32'h1));
    repeat (2) tick();
    chk("count_2", {27'd0, insert_count}, 32'd2);

    // external clear coincident with an insert in S2
    send(1'b1, 32'hDEAD_BEE0);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    chk("clr_event", {31'd0, clear_event}, 32'd1);
    chk("clr_count", {27'd0, insert_count}, 32'd0);
    chk("clr_ready", {31'd0, req_ready}, 32'd0);
    expect_resp("clr_ins", 1'b1, mdl_hit(32'hDEAD_BEE0));
    mdl_clr();
    tick();
    chk("clr_event_single", {31'd0, clear_event}, 32'd0);
    chk("clr_ready_back", {31'd0, req_ready}, 32'd1);
    send(1'b0, 32'hDEAD_BEE0);
    expect_resp("clr_test", 1'b0, 1'b0);
    tick();
    chk("clr_count_hold", {27'd0, insert_count}, 32'd0);

    // capacity auto-clear
    rq.delete();
    for (int k = 0; k < 16; k++) adr[k] = 32'h0001_0000 + 32'(k) * 32'h40;
    for (int k = 0; k < 16; k++) send(1'b1, adr[k]);
    n_ce = 0;
    n_nr = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (clear_event) n_ce++;
      if (!req_ready) n_nr++;
    end
    chk("auto_events", 32'(n_ce), 32'd1);
    chk("auto_ready_low", 32'(n_nr), 32'd1);
    chk("auto_count", {27'd0, insert_count}, 32'd0);
    chk("auto_nresp", 32'(rq.size()), 32'd16);
    for (int k = 0; k < 16; k++) begin
      expect_resp($sformatf("auto_%0d", k), 1'b1, mdl_hit(adr[k]));
      if (k < 15) mdl_ins(adr[k]);
    end
    mdl_clr();
    send(1'b0, adr[0]);
    expect_resp("auto_test_first", 1'b0, 1'b0);

    // reset with requests in flight
    send(1'b1, 32'h0000_0770);
    expect_resp("pre_rst_ins", 1'b1, 1'b0);
    tick();
    chk("pre_rst_count", {27'd0, insert_count}, 32'd1);
    rq.delete();
    send(1'b1, 32'h0000_0A00);
    req_valid  = 1'b1;
    req_insert = 1'b0;
    req_addr   = 32'h0000_0B00;
    rst        = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("mid_rst_rvalid", {31'd0, resp_valid}, 32'd0);
    chk("mid_rst_ready", {31'd0, req_ready}, 32'd0);
    chk("mid_rst_count", {27'd0, insert_count}, 32'd0);
    chk("mid_rst_cevent", {31'd0, clear_event}, 32'd0);
    tick();
    rst = 1'b0;
    repeat (4) tick();
    chk("mid_rst_noresp", 32'(rq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/eaf_bloom_filter.md
Name: eaf_bloom_filter

Overview:
- Next-generation Evicted-Address Filter (EAF). A pipelined, parametrised Bloom filter sitting beside the cache controller.
- The cache inserts evicted line addresses. On a miss it tests the fill address; a hit means "recently evicted", and the cache then places the line at MRU priority.
- Generalises the single-hash combinational index generator to NUM_HASH configurable hash slices with registered storage.
- Adds valid/ready request handshake, insert counting, auto-reset on reaching cache capacity, and external clear.

Parameters:
- ADDR_W, 32, request address width (>=17).
- NUM_HASH, 4, number of hash slices / bit arrays (1..8).
- IDX_W, 8, index width per slice; each array holds 2^IDX_W bits; NUM_HASH*IDX_W <= 32.
- MAX_INSERTS, 16, inserts before auto-clear (cache line count).
- CNT_W, $clog2(MAX_INSERTS+1), insert counter width.
- HASH_C1, 32'h55555555, first multiplier constant.
- HASH_C2, 32'h9e3779b9, second multiplier constant (inverse golden ratio).

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_insert  in  1  1 = insert, 0 = test.
- req_addr  in  ADDR_W  line address.
- clear_i  in  1  synchronous flush of all arrays and counter.
- resp_valid  out  1  one-cycle pulse per accepted request.
- resp_hit  out  1  all NUM_HASH indexed bits were set (read before write).
- resp_insert  out  1  echoes the op of the responding request.
- insert_count  out  CNT_W  inserts since last clear.
- clear_event  out  1  one-cycle pulse when a clear (auto or external) takes effect.

Behaviour:
- Reset values: req_ready=0, resp_valid=0, resp_hit=0, resp_insert=0, insert_count=0, clear_event=0. All array bits are 0 and the S1 valid bit is 0. FSM enters CLEAR.
- Hash (32-bit, results mod 2^32): a = zero-extend/truncate req_addr to 32; h1 = (a ^ (a>>16)) * HASH_C1; h2 = (h1 ^ (h1>>16)) * HASH_C2. Slice i index = h2[i*IDX_W +: IDX_W].
- Pipeline:
  - S1 registers h2, op, valid on accept.
  - S2 reads all NUM_HASH bits, registers resp_hit/resp_insert/resp_valid, and for an insert sets the bits at the same edge.
  - Latency: accept at edge N, resp_valid high during cycle N+2. Throughput 1 request/cycle.
  - Back-to-back insert X then test X: the test sees the insert (the write lands the edge before the test's S2 read). No forwarding is needed.
- FSM:
  - RUN: req_ready=1.
  - CLEAR: req_ready=0, S1 holds its content (stall), S2 issues nothing. Lasts exactly 1 cycle, then RUN.
- Counter: each S2 insert increments insert_count, including inserts that hit.
- Auto-clear: when an S2 insert makes the count reach MAX_INSERTS:
  - Its bits are NOT written.
  - All arrays are zeroed and insert_count is set to 0 at that edge.
  - clear_event pulses next cycle; FSM goes to CLEAR.
  - That insert's response is still produced, with the hit evaluated pre-clear.
- clear_i: same effect as auto-clear at the next edge. It wins over a coincident S2 insert (bits dropped, count 0) and a coincident auto-clear (single clear_event).
- Tests never modify state.
- rst mid-operation: in-flight S1/S2 requests are discarded and no response is issued for them.
- resp_hit is only meaningful while resp_valid=1; it holds its last value otherwise.

Decomposition:
- Package eaf_pkg holds:
  - default hash constants HASH_C1/HASH_C2;
  - typedef eaf_state_e {RUN, CLEAR};
  - typedef struct eaf_s1_t {valid, insert, h2[31:0]}.
- Sub-module eaf_hash: purely combinational address-to-h2 unit, parametrised by ADDR_W/constants, instantiated once before S1.

Test Plan:
- Reset, then test addr 0x0000_0000 -> req_ready=0 for 1 cycle after rst, then 1; resp_valid at accept+2 with resp_hit=0.
- Insert 0x1234_5680, next cycle test 0x1234_5680 -> insert resp_hit=0, test resp_hit=1, insert_count=1.
- Insert 0x0, then test 0x0 with NUM_HASH=4, IDX_W=8 -> bit 0 of each array set; test hit=1. Test 0x0000_0001 -> hit matches a golden hash model.
- Issue MAX_INSERTS=16 distinct inserts back-to-back -> 16th response produced, clear_event pulse, req_ready low 1 cycle, insert_count=0; test of the 1st address -> hit=0.
- Assert clear_i in the same cycle an insert of 0xDEAD_BEE0 is in S2 -> single clear_event, count=0, subsequent test of 0xDEAD_BEE0 -> hit=0.
- Assert rst with two requests in flight -> no resp_valid for either; outputs at reset values next cycle.
